// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the pipelined RV32I control path.
// Opcodes, immediate-format codes, the control bundle and the per-stage record.
package ctrl_pkg;

  typedef enum logic [6:0] {
    RType       = 7'b0110011,
    Load        = 7'b0000011,
    IType       = 7'b0010011,
    Store       = 7'b0100011,
    Branch      = 7'b1100011,
    JumpLink    = 7'b1101111,
    JumpLinkReg = 7'b1100111,
    LoadUpp     = 7'b0110111,
    AddUpp      = 7'b0010111
  } opcode_e;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  typedef struct packed {
    logic       branch;
    logic       jlink;
    logic       result_src;
    logic       mem_write;
    logic       alu_src;
    logic [2:0] imm_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       pcsrc_reg;
    logic       store_pc;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic         valid;
    ctrl_bundle_t ctrl;
    logic         illegal;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational RV32I main decoder: opcode -> control bundle plus illegal flag.
// Unknown opcodes yield an all-zero bundle so they can never write state.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]   i_opcode,
  output ctrl_bundle_t o_ctrl,
  output logic         o_illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    o_ctrl    = CTRL_BUBBLE;
    o_illegal = 1'b0;
    case (i_opcode)
      RType: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      Load: begin
        o_ctrl.result_src = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.imm_src    = IMM_I;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.alu_op     = ALU_ADD;
      end
      IType: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_I;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      Store: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_S;
        o_ctrl.alu_op    = ALU_ADD;
      end
      Branch: begin
        o_ctrl.branch  = 1'b1;
        o_ctrl.imm_src = IMM_B;
        o_ctrl.alu_op  = ALU_BRANCH;
      end
      JumpLink: begin
        o_ctrl.jlink     = 1'b1;
        o_ctrl.imm_src   = IMM_J;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.store_pc  = 1'b1;
      end
      JumpLinkReg: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_I;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.pcsrc_reg = 1'b1;
        o_ctrl.store_pc  = 1'b1;
      end
      LoadUpp, AddUpp: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_U;
        o_ctrl.reg_write = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_pipeline.sv
// Pipelined control path: decode in ID, then carry the control bundle through
// ID/EX, MEM_STAGES EX/MEM registers and MEM/WB; counts retired instructions.
module control_pipeline
  import ctrl_pkg::*;
#(
  parameter int IMMSRC_W   = 3,
  parameter int ALUOP_W    = 2,
  parameter int MEM_STAGES = 1,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode_i,
  input  logic                valid_i,
  input  logic                stall_i,
  input  logic                flush_i,
  output logic [IMMSRC_W-1:0] ImmSrc_o,
  output logic                ALUSrc_ex_o,
  output logic [ALUOP_W-1:0]  ALUOp_ex_o,
  output logic                Branch_ex_o,
  output logic                Jlink_ex_o,
  output logic                PCSrcReg_ex_o,
  output logic                MemWrite_mem_o,
  output logic                RegWrite_wb_o,
  output logic                ResultSrc_wb_o,
  output logic                StorePC_wb_o,
  output logic                illegal_ex_o,
  output logic [CNT_W-1:0]    instret_o
);

  ctrl_bundle_t     w_ctrl;
  logic             w_illegal;
  stage_t           w_id;
  stage_t           r_idex;
  stage_t           r_exmem [MEM_STAGES];
  stage_t           r_memwb;
  logic [CNT_W-1:0] r_instret;

  ctrl_decode u_decode (
    .i_opcode  (opcode_i),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  // Stall, flush or an empty IF/ID all collapse into one bubble; illegal ops carry only the flag.
  always_comb begin
    w_id = STAGE_BUBBLE;
    if (valid_i && !stall_i && !flush_i) begin
      w_id.valid   = !w_illegal;
      w_id.ctrl    = w_ctrl;
      w_id.illegal = w_illegal;
    end
  end

  // NOTE: pipeline registers are reset (not left X) so a mid-stream reset kills in-flight writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idex <= STAGE_BUBBLE;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
      r_idex <= w_id;
    end
  end

  for (genvar k = 0; k < MEM_STAGES; k++) begin : g_exmem
    stage_t w_src;
    if (k == 0) begin : g_first
      assign w_src = r_idex;
    end else begin : g_next
      assign w_src = r_exmem[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_exmem[k] <= STAGE_BUBBLE;
      else     r_exmem[k] <= w_src;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_memwb   <= STAGE_BUBBLE;
      r_instret <= '0;
    end else begin
      r_memwb <= r_exmem[MEM_STAGES-1];
      if (r_memwb.valid) r_instret <= r_instret + CNT_W'(1);
    end
  end

  // WB consumes only a few fields; the remainder rides along for debug visibility.
  logic w_unused_wb;
  assign w_unused_wb = ^r_memwb;

  assign ImmSrc_o       = IMMSRC_W'(w_ctrl.imm_src);
  assign ALUSrc_ex_o    = r_idex.ctrl.alu_src;
  assign ALUOp_ex_o     = ALUOP_W'(r_idex.ctrl.alu_op);
  assign Branch_ex_o    = r_idex.ctrl.branch;
  assign Jlink_ex_o     = r_idex.ctrl.jlink;
  assign PCSrcReg_ex_o  = r_idex.ctrl.pcsrc_reg;
  assign illegal_ex_o   = r_idex.illegal;
  assign MemWrite_mem_o = r_exmem[MEM_STAGES-1].ctrl.mem_write;
  assign RegWrite_wb_o  = r_memwb.ctrl.reg_write;
  assign ResultSrc_wb_o = r_memwb.ctrl.result_src;
  assign StorePC_wb_o   = r_memwb.ctrl.store_pc;
  assign instret_o      = r_instret;

endmodule
